// File: rtl/blit_pkg.sv
// Shared types and constants for the blitter command scheduler.
// Command layout: {opcode[7:0], arg3, arg2, arg1}.
package blit_pkg;

    localparam int BLIT_CMD_W = 104;
    localparam int BLIT_OP_HI = 103;
    localparam int BLIT_OP_LO = 96;

    localparam logic [7:0] BLIT_OP_FENCE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        PRESENT,
        FENCE
    } blit_state_e;

    function automatic logic [7:0] blit_opcode(
        input logic [BLIT_CMD_W-1:0] cmd
    );
        return cmd[BLIT_OP_HI:BLIT_OP_LO];
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Registered-storage FIFO with head/tail pointers and an occupancy count.
// Pushes when full and pops when empty are ignored.
module cmd_fifo #(
    parameter int WIDTH = 104,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[head];

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + AW'(1);
            if (do_pop)  head <= head + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[tail] <= din;
    end

endmodule

// File: rtl/blit_sched.sv
// In-order blit command dispatcher with outstanding tracking and FENCE.
// Optional debug counters on stats when BLIT_SCHED_STATS_EN is defined.
module blit_sched
    import blit_pkg::*;
#(
    parameter int DEPTH           = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [BLIT_CMD_W-1:0] cmd_in,
    input  logic                  cmd_start,
    output logic [7:0]            slots_free,
    output logic                  overflow,
    output logic [BLIT_CMD_W-1:0] eng_cmd,
    output logic                  eng_valid,
    input  logic                  eng_ready,
    input  logic                  eng_done,
    output logic                  busy,
    output logic [31:0]           stats
);

    localparam int CW = $clog2(DEPTH) + 1;

    blit_state_e           state;
    blit_state_e           state_nx;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic [BLIT_CMD_W-1:0] head_cmd;
    logic                  pop;
    logic                  load;
    logic                  hs;
    logic                  done_ok;
    logic                  can_issue;
    logic                  head_fence;
    logic [3:0]            outstanding;

    cmd_fifo #(
        .WIDTH (BLIT_CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (cmd_start),
        .pop   (pop),
        .din   (cmd_in),
        .dout  (head_cmd),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign hs         = eng_valid && eng_ready;
    assign done_ok    = eng_done && (outstanding != 4'd0);
    assign can_issue  = outstanding < 4'(MAX_OUTSTANDING);
    assign head_fence = blit_opcode(head_cmd) == BLIT_OP_FENCE;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // IDLE also leaves on an incoming push so HEAD is reached the next cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (!empty || cmd_start) state_nx = HEAD;
            end
            HEAD: begin
                if (empty)           state_nx = IDLE;
                else if (head_fence) state_nx = FENCE;
                else if (can_issue)  state_nx = PRESENT;
            end
            PRESENT: begin
                if (eng_ready) state_nx = empty ? IDLE : HEAD;
            end
            FENCE: begin
                if (outstanding == 4'd0)
                    state_nx = (count > CW'(1)) ? HEAD : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pop  = 1'b0;
        load = 1'b0;
        unique case (state)
            HEAD: begin
                if (!empty && !head_fence && can_issue) begin
                    pop  = 1'b1;
                    load = 1'b1;
                end
            end
            FENCE: begin
                if (outstanding == 4'd0) pop = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            eng_cmd   <= '0;
            eng_valid <= 1'b0;
        end else if (load) begin
            eng_cmd   <= head_cmd;
            eng_valid <= 1'b1;
        end else if (hs) begin
            eng_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            outstanding <= 4'd0;
        end else if (hs && !done_ok) begin
            outstanding <= outstanding + 4'd1;
        end else if (!hs && done_ok) begin
            outstanding <= outstanding - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)                  overflow <= 1'b0;
        else if (cmd_start && full) overflow <= 1'b1;
    end

    assign slots_free = 8'(DEPTH) - 8'(count);
    assign busy       = !empty || eng_valid || (outstanding != 4'd0);

`ifdef BLIT_SCHED_STATS_EN
    logic [15:0] n_cmd;
    logic [7:0]  n_fence;

    always_ff @(posedge clock) begin
        if (reset) begin
            n_cmd   <= '0;
            n_fence <= '0;
        end else begin
            if (hs)                      n_cmd   <= n_cmd + 16'd1;
            if (state == FENCE && pop)   n_fence <= n_fence + 8'd1;
        end
    end

    assign stats = {overflow, 3'b000, outstanding, n_fence, n_cmd};
`else
    assign stats = 32'h0;
`endif

endmodule

// File: tb/tb_blit_sched.sv
// Self-checking bench for blit_sched: vector table, directed corner
// sequences and randomized bursts against an in-order dispatch model.
module tb_blit_sched;
    import blit_pkg::*;

    localparam int DEPTH = 16;
    localparam int MAXO  = 4;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [BLIT_CMD_W-1:0] cmd_in = '0;
    logic                  cmd_start = 1'b0;
    logic [7:0]            slots_free;
    logic                  overflow;
    logic [BLIT_CMD_W-1:0] eng_cmd;
    logic                  eng_valid;
    logic                  eng_ready = 1'b0;
    logic                  eng_done = 1'b0;
    logic                  busy;
    logic [31:0]           stats;

    int n_tests = 0;
    int n_fail  = 0;

    logic [BLIT_CMD_W-1:0] hs_q [$];

    blit_sched #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_in     (cmd_in),
        .cmd_start  (cmd_start),
        .slots_free (slots_free),
        .overflow   (overflow),
        .eng_cmd    (eng_cmd),
        .eng_valid  (eng_valid),
        .eng_ready  (eng_ready),
        .eng_done   (eng_done),
        .busy       (busy),
        .stats      (stats)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [BLIT_CMD_W-1:0] mk(input logic [7:0] op,
                                                 input logic [31:0] a1);
        return {op, 32'h3333_0000, 32'h2222_0000, a1};
    endfunction

    task automatic step();
        @(negedge clock);
    endtask

    task automatic push(input logic [BLIT_CMD_W-1:0] c);
        cmd_in    = c;
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        cmd_start = 1'b0;
        eng_ready = 1'b0;
        eng_done  = 1'b0;
        step();
        step();
        reset = 1'b0;
        hs_q.delete();
    endtask

    task automatic drain(input int cap);
        eng_ready = 1'b1;
        eng_done  = 1'b1;
        for (int k = 0; k < cap && busy; k++) step();
        eng_done  = 1'b0;
        check("drain_idle", busy, 1'b0);
    endtask

    // Handshake capture and hold-stability monitor
    logic                  pv = 1'b0;
    logic                  pr = 1'b0;
    logic                  prst = 1'b1;
    logic [BLIT_CMD_W-1:0] pc = '0;

    always @(posedge clock) begin
        if (!prst && pv && !pr) begin
            check("hold_valid", eng_valid, 1'b1);
            check("hold_cmd", eng_cmd, pc);
        end
        if (!reset && eng_valid && eng_ready) hs_q.push_back(eng_cmd);
        pv   <= eng_valid;
        pr   <= eng_ready;
        pc   <= eng_cmd;
        prst <= reset;
    end

    typedef struct {
        logic       st;
        logic [7:0] op;
        logic       rdy;
        logic       dn;
        logic [7:0] slots;
        logic       vld;
        logic       bsy;
        logic       ovf;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [BLIT_CMD_W-1:0] c;
        logic [BLIT_CMD_W-1:0] exp_all [$];
        int                    dones;
        int                    out_m;
        int                    base;
        int                    pushed;

        tbl[0] = '{1'b1, 8'h01, 1'b0, 1'b0, 8'd15, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'd16, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'd16, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'd16, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'd16, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'd15, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'd15, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'd16, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'd16, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'd16, 1'b0, 1'b0, 1'b0};

        // Reset values
        do_reset();
        check("rst_slots", slots_free, 8'd16);
        check("rst_ovf", overflow, 1'b0);
        check("rst_cmd", eng_cmd, 0);
        check("rst_valid", eng_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_stats", stats, 32'h0);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            cmd_in    = mk(tbl[i].op, 32'(i));
            cmd_start = tbl[i].st;
            eng_ready = tbl[i].rdy;
            eng_done  = tbl[i].dn;
            step();
            check($sformatf("vec%0d_slots", i), slots_free, tbl[i].slots);
            check($sformatf("vec%0d_valid", i), eng_valid, tbl[i].vld);
            check($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
            check($sformatf("vec%0d_ovf", i), overflow, tbl[i].ovf);
        end
        cmd_start = 1'b0;
        eng_ready = 1'b0;
        eng_done  = 1'b0;
        check("vec_hs_count", hs_q.size(), 1);

        // Latency into an empty queue
        do_reset();
        eng_ready = 1'b1;
        c = mk(8'h01, 32'h0010_0020);
        push(c);
        check("lat_n1_slots", slots_free, 8'd15);
        check("lat_n1_valid", eng_valid, 1'b0);
        step();
        check("lat_n2_valid", eng_valid, 1'b1);
        check("lat_n2_op", eng_cmd[103:96], 8'h01);
        check("lat_n2_cmd", eng_cmd, c);
        check("lat_n2_slots", slots_free, 8'd16);
        step();
        check("lat_hs", hs_q.size(), 1);
        check("lat_valid_clr", eng_valid, 1'b0);
        drain(20);

        // Overflow: one command sits in eng_cmd, sixteen fill the queue
        do_reset();
        for (int i = 0; i < 18; i++) push(mk(8'h10, 32'(i)));
        check("ovf_slots", slots_free, 8'd0);
        check("ovf_flag", overflow, 1'b1);
        drain(300);
        check("ovf_hs_count", hs_q.size(), 17);
        for (int i = 0; i < 17 && i < hs_q.size(); i++)
            check($sformatf("ovf_order%0d", i), hs_q[i][31:0], 32'(i));
        check("ovf_sticky", overflow, 1'b1);

        // Fence release timing
        do_reset();
        eng_ready = 1'b1;
        push(mk(8'h02, 32'hAAAA));
        push(mk(BLIT_OP_FENCE, 32'h0));
        push(mk(8'h03, 32'hBBBB));
        for (int k = 0; k < 20 && hs_q.size() < 1; k++) step();
        check("fence_a_hs", hs_q.size(), 1);
        for (int k = 0; k < 9; k++) begin
            step();
            check("fence_wait_valid", eng_valid, 1'b0);
        end
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        check("fence_m1_valid", eng_valid, 1'b0);
        step();
        check("fence_m2_valid", eng_valid, 1'b0);
        step();
        check("fence_m3_valid", eng_valid, 1'b1);
        check("fence_m3_op", eng_cmd[103:96], 8'h03);
        step();
        drain(20);
        check("fence_hs_count", hs_q.size(), 2);

        // Outstanding limit
        do_reset();
        eng_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(mk(8'h20, 32'(i)));
        for (int k = 0; k < 14; k++) step();
        check("max_hs4", hs_q.size(), 4);
        check("max_busy", busy, 1'b1);
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check("max_hs5", hs_q.size(), 5);
        drain(100);
        check("max_hs6", hs_q.size(), 6);

        // eng_cmd held while the engine stalls
        do_reset();
        c = mk(8'h30, 32'hCAFE);
        push(c);
        for (int k = 0; k < 10 && !eng_valid; k++) step();
        for (int k = 0; k < 5; k++) begin
            check("stall_cmd", eng_cmd, c);
            check("stall_valid", eng_valid, 1'b1);
            step();
        end
        eng_ready = 1'b1;
        step();
        eng_ready = 1'b0;
        check("stall_hs1", hs_q.size(), 1);
        check("stall_valid_clr", eng_valid, 1'b0);
        step();
        step();
        check("stall_hs_once", hs_q.size(), 1);
        drain(20);

        // Reset with three queued and two outstanding
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cmd_in    = mk(8'h40, 32'(i));
            cmd_start = 1'b1;
            eng_ready = hs_q.size() < 2;
            step();
        end
        cmd_start = 1'b0;
        eng_ready = 1'b0;
        check("mid_hs2", hs_q.size(), 2);
        check("mid_slots13", slots_free, 8'd13);
        check("mid_busy", busy, 1'b1);
        reset = 1'b1;
        step();
        check("mid_rst_slots", slots_free, 8'd16);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", eng_valid, 1'b0);
        reset    = 1'b0;
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        check("mid_stray_done", busy, 1'b0);
        step();
        check("mid_stray_done2", busy, 1'b0);

        // Randomized bursts against the in-order model
        do_reset();
        dones = 0;
        for (int b = 0; b < 8; b++) begin
            base   = exp_all.size();
            pushed = 0;
            for (int k = 0; k < 30; k++) begin
                cmd_start = (pushed < 12) && ($urandom_range(2) == 0);
                c = {($urandom_range(4) == 0) ? BLIT_OP_FENCE
                                              : 8'($urandom_range(254)),
                     $urandom(), $urandom(), $urandom()};
                cmd_in = c;
                if (cmd_start) begin
                    pushed++;
                    if (c[103:96] != BLIT_OP_FENCE) exp_all.push_back(c);
                end
                out_m     = hs_q.size() - dones;
                eng_ready = $urandom_range(1);
                eng_done  = (out_m > 0) && ($urandom_range(2) == 0);
                step();
                if (eng_done) dones++;
                check("rnd_out_le_max", (hs_q.size() - dones) <= MAXO, 1'b1);
            end
            cmd_start = 1'b0;
            for (int k = 0; k < 600 && (busy || hs_q.size() > dones); k++) begin
                out_m     = hs_q.size() - dones;
                eng_ready = $urandom_range(1);
                eng_done  = (out_m > 0) && ($urandom_range(1) == 0);
                step();
                if (eng_done) dones++;
            end
            eng_ready = 1'b0;
            eng_done  = 1'b0;
            check("rnd_idle", busy, 1'b0);
            check("rnd_ovf", overflow, 1'b0);
            check("rnd_count", hs_q.size(), exp_all.size());
            for (int i = base; i < exp_all.size() && i < hs_q.size(); i++)
                check($sformatf("rnd_b%0d_i%0d", b, i), hs_q[i], exp_all[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
